// File: rtl/wb_rr_arbiter_pkg.sv
// rtl/wb_rr_arbiter_pkg.sv - shared constants for the Wishbone round-robin arbiter
// Contents:
//   ARB_*          arbiter FSM state encodings
//   CTI_*          Wishbone cycle-type codes
//   idx_width(n)   index width that stays at least 1 bit for n <= 1
package wb_rr_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_OWN   = 2'd1;
    localparam logic [1:0] ARB_ABORT = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin picker
// Ports:
//   i_req      request vector, one bit per requester
//   i_ptr      highest-priority index for this pick
//   o_gnt      one-hot grant (0 when nothing requests)
//   o_gnt_idx  binary index of the grant
//   o_valid    at least one request present
module wb_rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = idx_width(NM)
) (
    input  logic [NM-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [NM-1:0] o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_valid
);

    int w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_valid   = 1'b0;
        w_idx     = 0;
        // Scan from the farthest offset back to the pointer so the requester
        // nearest to (at or above) the pointer is the last, winning assignment.
        for (int k = NM - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NM;
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = IW'(w_idx);
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter, cycle-level grant with watchdog
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbm_*_i              per-master request vectors, master i in slice [i*W +: W]
//   wbm_dat_o            read data broadcast to all masters
//   wbm_ack/err/rty_o    responses, only the owner's bit can be set
//   wbs_*_o / wbs_*_i    single slave port (muxed request, raw response)
//   grant_o              one-hot current owner, 0 when idle
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]        wbm_we_i,
    input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
    output logic [DW-1:0]                 wbm_dat_o,
    output logic [NUM_MASTERS-1:0]        wbm_ack_o,
    output logic [NUM_MASTERS-1:0]        wbm_err_o,
    output logic [NUM_MASTERS-1:0]        wbm_rty_o,
    output logic [AW-1:0]                 wbs_adr_o,
    output logic [DW-1:0]                 wbs_dat_o,
    output logic [DW/8-1:0]               wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    output logic [2:0]                    wbs_cti_o,
    output logic [1:0]                    wbs_bte_o,
    input  logic [DW-1:0]                 wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    input  logic                          wbs_rty_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int NM  = NUM_MASTERS;
    localparam int IW  = idx_width(NM);
    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

    logic [1:0]     r_state;
    logic [NM-1:0]  r_grant;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  r_rr_ptr;
    logic [WDW-1:0] r_wd;
    logic           r_abort_err;

    logic [NM-1:0]  w_pick_gnt;
    logic [IW-1:0]  w_pick_idx;
    logic           w_pick_valid;
    logic [IW-1:0]  w_ptr_next;
    logic           w_own;
    logic           w_owner_cyc;
    logic           w_owner_stb;
    logic           w_term;
    logic           w_wd_expire;

    wb_rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .i_req     (wbm_cyc_i),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_pick_gnt),
        .o_gnt_idx (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    assign w_ptr_next  = (w_pick_idx == IW'(NM - 1)) ? '0 : w_pick_idx + IW'(1);
    assign w_own       = (r_state == ARB_OWN);
    assign w_owner_cyc = wbm_cyc_i[r_owner];
    assign w_owner_stb = wbm_stb_i[r_owner];
    assign w_term      = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // Request path: the slave only sees cyc/stb while in OWN; in ABORT the
    // owner's cycle is cut off even though it still holds cyc.
    assign wbs_cyc_o = w_own & w_owner_cyc;
    assign wbs_stb_o = wbs_cyc_o & w_owner_stb;
    assign wbs_adr_o = wbm_adr_i[int'(r_owner)*AW +: AW];
    assign wbs_dat_o = wbm_dat_i[int'(r_owner)*DW +: DW];
    assign wbs_sel_o = wbm_sel_i[int'(r_owner)*(DW/8) +: DW/8];
    assign wbs_we_o  = wbm_we_i[r_owner];
    assign wbs_cti_o = wbm_cti_i[int'(r_owner)*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[int'(r_owner)*2 +: 2];

    // Response path: slave terminations reach the owner only in OWN, so late
    // acks arriving during ABORT are dropped. The abort err is a one-cycle pulse.
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = w_own ? (r_grant & {NM{wbs_ack_i}}) : '0;
    assign wbm_rty_o = w_own ? (r_grant & {NM{wbs_rty_i}}) : '0;
    assign wbm_err_o = (w_own ? (r_grant & {NM{wbs_err_i}}) : '0) | (r_grant & {NM{r_abort_err}});
    assign grant_o   = r_grant;

    // A termination in the expiry cycle keeps the owner alive.
    assign w_wd_expire = WD_EN & wbs_stb_o & ~w_term & (r_wd == WD_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_wd        <= '0;
            r_abort_err <= 1'b0;
        end else begin
            r_abort_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_wd <= '0;
                    if (w_pick_valid) begin
                        r_grant  <= w_pick_gnt;
                        r_owner  <= w_pick_idx;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (!w_owner_cyc) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                        r_wd    <= '0;
                    end else if (w_wd_expire) begin
                        r_state     <= ARB_ABORT;
                        r_abort_err <= 1'b1;
                        r_wd        <= '0;
                    end else if (WD_EN && wbs_stb_o && !w_term) begin
                        r_wd <= r_wd + WDW'(1);
                    end else begin
                        r_wd <= '0;
                    end
                end
                ARB_ABORT: begin
                    if (!w_owner_cyc) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
